// File: rtl/fractal_sync_rf_scheduler.sv
// fractal_sync_rf_scheduler: rotating-priority arbiter sharing local RF check ports, with registered per-port responses
package fractal_sync_pkg;
  localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_rf_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ID_WIDTH = 4,
  localparam int unsigned SD_WIDTH = fractal_sync_pkg::SD_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [ID_WIDTH-1:0] req_id_i [N_REQ],
  input  logic [SD_WIDTH-1:0] req_sd_i [N_REQ],
  output logic [ID_WIDTH-1:0] rf_id_o [N_PORTS],
  output logic [N_PORTS-1:0]  rf_check_o,
  output logic [SD_WIDTH-1:0] rf_sd_o [N_PORTS],
  input  logic [N_PORTS-1:0]  rf_present_i,
  input  logic [N_PORTS-1:0]  rf_id_err_i,
  input  logic [N_PORTS-1:0]  rf_bypass_i,
  input  logic [N_PORTS-1:0]  rf_ignore_i,
  input  logic [SD_WIDTH-1:0] rf_sd_i [N_PORTS],
  output logic [N_PORTS-1:0]  rsp_valid_o,
  input  logic [N_PORTS-1:0]  rsp_ready_i,
  output logic [1:0]          rsp_kind_o [N_PORTS],
  output logic [ID_WIDTH-1:0] rsp_id_o [N_PORTS],
  output logic [SD_WIDTH-1:0] rsp_sd_o [N_PORTS],
  output logic [SD_WIDTH-1:0] rsp_peer_sd_o [N_PORTS]
);
  localparam int unsigned PW = $clog2(N_REQ);
  localparam logic [1:0] STORED = 2'd0, MATCH = 2'd1, ERROR = 2'd2;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                stall;
  logic [1:0]          kind_d [N_PORTS];
  logic [SD_WIDTH-1:0] peer_d [N_PORTS];
  logic [N_PORTS-1:0]  rsp_valid_q;
  logic [1:0]          rsp_kind_q [N_PORTS];
  logic [ID_WIDTH-1:0] rsp_id_q [N_PORTS];
  logic [SD_WIDTH-1:0] rsp_sd_q [N_PORTS];
  logic [SD_WIDTH-1:0] rsp_peer_q [N_PORTS];

  assign stall = |(rsp_valid_q & ~rsp_ready_i);

  // k-th valid requester found from ptr_q onwards lands on port k
  always_comb begin : arb
    int unsigned cnt;
    cnt = 0;
    req_ready_o = '0;
    rf_check_o = '0;
    ptr_d = ptr_q;
    for (int p = 0; p < N_PORTS; p++) begin
      rf_id_o[p] = '0;
      rf_sd_o[p] = '0;
    end
    for (int i = 0; i < N_REQ; i++)
      for (int r = 0; r < N_REQ; r++)
        if (rst_ni && !stall && req_valid_i[r] && cnt < N_PORTS &&
            r == (int'(ptr_q) + i) % N_REQ) begin
          for (int p = 0; p < N_PORTS; p++)
            if (p == cnt) begin
              rf_check_o[p] = 1'b1;
              rf_id_o[p] = req_id_i[r];
              rf_sd_o[p] = req_sd_i[r];
            end
          req_ready_o[r] = 1'b1;
          ptr_d = PW'((r + 1) % N_REQ);
          cnt++;
        end
  end

  // a bypass/ignore pair sharing a local id matches each other within the same cycle
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      kind_d[p] = rf_id_err_i[p] ? ERROR :
                  (rf_bypass_i[p] | rf_ignore_i[p] | rf_present_i[p]) ? MATCH : STORED;
      peer_d[p] = (!rf_id_err_i[p] && !rf_bypass_i[p] && !rf_ignore_i[p] && rf_present_i[p]) ?
                  rf_sd_i[p] : '0;
      if (!rf_id_err_i[p] && rf_bypass_i[p]) begin
        for (int q = int'(N_PORTS) - 1; q > p; q--)
          if (rf_check_o[q] && rf_ignore_i[q] &&
              rf_id_o[q][ID_WIDTH-1:1] == rf_id_o[p][ID_WIDTH-1:1])
            peer_d[p] = rf_sd_o[q];
      end else if (!rf_id_err_i[p] && rf_ignore_i[p]) begin
        for (int q = 0; q < p; q++)
          if (rf_check_o[q] && rf_bypass_i[q] &&
              rf_id_o[q][ID_WIDTH-1:1] == rf_id_o[p][ID_WIDTH-1:1])
            peer_d[p] = rf_sd_o[q];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rsp_valid_q <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_kind_q[p] <= '0;
        rsp_id_q[p] <= '0;
        rsp_sd_q[p] <= '0;
        rsp_peer_q[p] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int p = 0; p < N_PORTS; p++)
        if (rf_check_o[p]) begin
          rsp_valid_q[p] <= 1'b1;
          rsp_kind_q[p] <= kind_d[p];
          rsp_id_q[p] <= rf_id_o[p];
          rsp_sd_q[p] <= rf_sd_o[p];
          rsp_peer_q[p] <= peer_d[p];
        end else if (rsp_valid_q[p] && rsp_ready_i[p]) begin
          rsp_valid_q[p] <= 1'b0;
          rsp_kind_q[p] <= '0;
          rsp_id_q[p] <= '0;
          rsp_sd_q[p] <= '0;
          rsp_peer_q[p] <= '0;
        end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_kind_o = rsp_kind_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_sd_o = rsp_sd_q;
  assign rsp_peer_sd_o = rsp_peer_q;
endmodule

// File: tb/tb_fractal_sync_rf_scheduler.sv
// tb_fractal_sync_rf_scheduler: scoreboard bench for the RF scheduler
module tb_fractal_sync_rf_scheduler;
  localparam int NR = 4, NP = 2, IW = 4, SW = fractal_sync_pkg::SD_WIDTH;

  typedef struct packed {
    logic [7:0]    p;
    logic [1:0]    k;
    logic [IW-1:0] id;
    logic [SW-1:0] sd;
    logic [SW-1:0] peer;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0;

  logic          clk_i = 1'b0, rst_ni = 1'b1;
  logic [NR-1:0] req_valid, req_ready;
  logic [IW-1:0] req_id [NR];
  logic [SW-1:0] req_sd [NR];
  logic [IW-1:0] rf_id [NP];
  logic [NP-1:0] rf_check, rf_present, rf_id_err, rf_bypass, rf_ignore;
  logic [SW-1:0] rf_sd_o [NP];
  logic [SW-1:0] rf_sd [NP];
  logic [NP-1:0] rsp_valid, rsp_ready;
  logic [1:0]    rsp_kind [NP];
  logic [IW-1:0] rsp_id [NP];
  logic [SW-1:0] rsp_sd [NP];
  logic [SW-1:0] rsp_peer [NP];

  fractal_sync_rf_scheduler #(.N_REQ(NR), .N_PORTS(NP), .ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id), .req_sd_i(req_sd),
    .rf_id_o(rf_id), .rf_check_o(rf_check), .rf_sd_o(rf_sd_o),
    .rf_present_i(rf_present), .rf_id_err_i(rf_id_err), .rf_bypass_i(rf_bypass),
    .rf_ignore_i(rf_ignore), .rf_sd_i(rf_sd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_kind_o(rsp_kind),
    .rsp_id_o(rsp_id), .rsp_sd_o(rsp_sd), .rsp_peer_sd_o(rsp_peer)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int k, input int id, input int sd, input int peer);
    exp_t e;
    e.p = 8'(p);
    e.k = 2'(k);
    e.id = IW'(id);
    e.sd = SW'(sd);
    e.peer = SW'(peer);
    sb.push_back(e);
  endtask

  task automatic clr();
    req_valid = '0;
    rf_present = '0;
    rf_id_err = '0;
    rf_bypass = '0;
    rf_ignore = '0;
    for (int i = 0; i < NP; i++) rf_sd[i] = '0;
  endtask

  task automatic set_req(input int r, input int id, input int sd);
    req_valid[r] = 1'b1;
    req_id[r] = IW'(id);
    req_sd[r] = SW'(sd);
  endtask

  task automatic nxt();
    @(negedge clk_i);
    clr();
  endtask

  task automatic grants(input string tag, input logic [NR-1:0] rdy, input logic [NP-1:0] ck);
    #2;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(rdy));
    chk({tag, "_chk"}, 32'(rf_check), 32'(ck));
  endtask

  // responses accepted this cycle are matched against the oldest expectation for that port
  always begin
    @(negedge clk_i);
    #4;
    for (int p = 0; p < NP; p++)
      if (rsp_valid[p] && rsp_ready[p]) begin
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].p == 8'(p)) idx = i;
        if (idx < 0) chk($sformatf("rsp%0d_unexpected", p), 1, 0);
        else begin
          chk($sformatf("rsp%0d", p), 32'({rsp_kind[p], rsp_id[p], rsp_sd[p], rsp_peer[p]}),
              32'({sb[idx].k, sb[idx].id, sb[idx].sd, sb[idx].peer}));
          sb.delete(idx);
        end
      end
  end

  initial begin
    rsp_ready = '1;
    clr();
    for (int r = 0; r < NR; r++) begin
      req_id[r] = '0;
      req_sd[r] = '0;
    end
    #1 rst_ni = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, r * 2, r);
    repeat (2) @(negedge clk_i);
    #2;
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_chk", 32'(rf_check), 0);
    chk("rst_vld", 32'(rsp_valid), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    grants("rel", 4'b0011, 2'b11);
    push(0, 0, 0, 0, 0);
    push(1, 0, 2, 1, 0);
    nxt();
    nxt();
    set_req(0, 2, 1);
    grants("stored", 4'b0001, 2'b01);
    chk("stored_id", 32'(rf_id[0]), 2);
    push(0, 0, 2, 1, 0);
    nxt();
    set_req(1, 2, 2);
    rf_present[0] = 1'b1;
    rf_sd[0] = 1;
    grants("match", 4'b0010, 2'b01);
    push(0, 1, 2, 2, 1);
    nxt();
    set_req(0, 6, 1);
    set_req(1, 6, 2);
    rf_bypass = 2'b01;
    rf_ignore = 2'b10;
    grants("pair", 4'b0011, 2'b11);
    push(0, 1, 6, 1, 2);
    push(1, 1, 6, 2, 1);
    nxt();
    set_req(2, 14, 3);
    rf_id_err = 2'b01;
    grants("err", 4'b0100, 2'b01);
    chk("err_id", 32'(rf_id[0]), 14);
    push(0, 2, 14, 3, 0);
    nxt();
    set_req(3, 8, 0);
    grants("req3", 4'b1000, 2'b01);
    push(0, 0, 8, 0, 0);
    nxt();
    for (int r = 0; r < NR; r++) set_req(r, r * 2, r);
    grants("all_n", 4'b0011, 2'b11);
    chk("all_n_id1", 32'(rf_id[1]), 2);
    push(0, 0, 0, 0, 0);
    push(1, 0, 2, 1, 0);
    nxt();
    for (int r = 0; r < NR; r++) set_req(r, r * 2, r);
    grants("all_n1", 4'b1100, 2'b11);
    chk("all_n1_id0", 32'(rf_id[0]), 4);
    push(0, 0, 4, 2, 0);
    push(1, 0, 6, 3, 0);
    nxt();
    set_req(0, 10, 1);
    set_req(1, 12, 2);
    grants("pre_stall", 4'b0011, 2'b11);
    push(0, 0, 10, 1, 0);
    push(1, 0, 12, 2, 0);
    for (int c = 0; c < 3; c++) begin
      nxt();
      rsp_ready = 2'b01;
      set_req(0, 0, 2);
      set_req(1, 4, 3);
      grants("stall", 4'b0000, 2'b00);
      chk("stall_v1", 32'(rsp_valid[1]), 1);
      chk("stall_id1", 32'(rsp_id[1]), 12);
      chk("stall_v0", 32'(rsp_valid[0]), (c == 0) ? 1 : 0);
    end
    nxt();
    rsp_ready = 2'b11;
    set_req(0, 0, 2);
    set_req(1, 4, 3);
    grants("resume", 4'b0011, 2'b11);
    push(0, 0, 0, 2, 0);
    push(1, 0, 4, 3, 0);
    repeat (3) nxt();
    chk("sb_empty", 32'(sb.size()), 0);
    nxt();
    set_req(1, 2, 1);
    grants("pre_rst", 4'b0010, 2'b01);
    nxt();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_vld", 32'(rsp_valid), 0);
    chk("arst_id0", 32'(rsp_id[0]), 0);
    nxt();
    rst_ni = 1'b1;
    for (int r = 0; r < NR; r++) set_req(r, r * 2, r);
    grants("post_rst", 4'b0011, 2'b11);
    push(0, 0, 0, 0, 0);
    push(1, 0, 2, 1, 0);
    repeat (3) nxt();
    chk("sb_empty_end", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fractal_sync_rf_scheduler.md
# fractal_sync_rf_scheduler

Arbiter and sequencer in front of a fractal-sync 1D local register file. It shares the RF's N_PORTS check ports among N_REQ synchronization requesters using rotating-priority grants, and drives id/check/sd into the RF. It classifies the RF's combinational verdict (stored, matched, bypass/ignore pair, id error) and returns one registered response per granted request under valid/ready backpressure. It sits between the node's request inputs and its local RF instance.

## Interface
- N_REQ, 4, number of requesters (>= N_PORTS)
- N_PORTS, 2, number of RF ports (>= 2)
- ID_WIDTH, 4, barrier id width (>= 2); local id = id[ID_WIDTH-1:1]
- SD_WIDTH, fractal_sync_pkg::SD_WIDTH, source/destination width (localparam)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i[N_REQ]  in  1  request valid; held until accepted
- req_ready_o[N_REQ]  out  1  request granted this cycle (combinational)
- req_id_i[N_REQ]  in  ID_WIDTH  barrier id
- req_sd_i[N_REQ]  in  SD_WIDTH  requester source
- rf_id_o[N_PORTS]  out  ID_WIDTH  id to RF port
- rf_check_o[N_PORTS]  out  1  RF check strobe
- rf_sd_o[N_PORTS]  out  SD_WIDTH  sd to RF port
- rf_present_i / rf_id_err_i / rf_bypass_i / rf_ignore_i[N_PORTS]  in  1  RF verdicts (same cycle)
- rf_sd_i[N_PORTS]  in  SD_WIDTH  stored sd returned by RF
- rsp_valid_o[N_PORTS]  out  1  response slot valid
- rsp_ready_i[N_PORTS]  in  1  response accepted
- rsp_kind_o[N_PORTS]  out  2  0 STORED, 1 MATCH, 2 ERROR
- rsp_id_o[N_PORTS]  out  ID_WIDTH  id of the answered request
- rsp_sd_o[N_PORTS]  out  SD_WIDTH  sd of the answered requester
- rsp_peer_sd_o[N_PORTS]  out  SD_WIDTH  partner sd (MATCH only, else 0)

## Operation
- stall = OR over p of (rsp_valid_o[p] & ~rsp_ready_i[p]). While stall is high or rst_ni is low: no grants, all req_ready_o = 0, all rf_check_o = 0.
- Arbitration: scan r = ptr_q, ptr_q+1, ... mod N_REQ. The k-th valid requester found goes to port k, for k < N_PORTS. Each requester is granted at most once per cycle.
- Ungranted ports drive check = 0, id = 0, sd = 0.
- ptr_q (reset 0): on any grant, load (index of last granted requester + 1) mod N_REQ. With no grant, hold.
- Classification of each granted port p, in priority order:
  - rf_id_err_i -> ERROR, peer 0.
  - rf_bypass_i -> MATCH; peer = sd of lowest port q > p granted with equal local id and rf_ignore_i[q].
  - rf_ignore_i -> MATCH; peer = sd of highest port q < p granted with equal local id and rf_bypass_i[q].
  - rf_present_i -> MATCH, peer = rf_sd_i[p].
  - Otherwise STORED, peer 0.
- Response slot p:
  - Loads kind, id, sd and peer when port p is granted.
  - Clears on rsp_valid & rsp_ready when not reloaded in the same cycle.
  - Holds otherwise.
- Every accepted request yields exactly one response, STORED included.

## Timing
- Grant, RF drive and classification happen in the same cycle. The response is valid in the next cycle: latency 1.
- Throughput is N_PORTS requests/cycle while all rsp_ready_i are high. A slot that is consumed and reloaded in the same cycle shows the new data with no bubble.
- Any single unready valid slot stalls all grants. Other slots with rsp_ready high still drain during the stall.
- Reset (asynchronous, including mid-operation): all rsp_* = 0 and ptr_q = 0. Pending responses are dropped; requesters must re-issue. rf_*_o and req_ready_o = 0 while rst_ni is low.
- Fewer valid requesters than ports: only the low ports are used. Pointer wrap is mod N_REQ, with no skipped requester.
- Same requester valid on consecutive cycles with new data: it is treated as a new request after each acceptance.

## Test plan
- Reset with all req_valid_i = 1 -> all req_ready_o, rf_check_o and rsp_valid_o stay 0. After release, requesters 0 and 1 are granted on ports 0 and 1.
- req0 id=4'b0010 sd=1 alone -> rf_check_o[0]=1, rf_id_o[0]=2, next cycle rsp kind=STORED. Then req1 id=2 sd=2 with RF rf_present_i[0]=1 and rf_sd_i[0]=1 -> kind=MATCH, peer_sd=1.
- req0 id=6 sd=1 and req1 id=6 sd=2 in the same cycle (RF bypass[0], ignore[1]) -> both slots MATCH, peer_sd 2 and 1 respectively.
- req2 id=4'b1110 with rf_id_err_i=1 -> kind=ERROR, peer_sd=0, id=14.
- All 4 valid with distinct ids and rsp_ready_i high -> cycle n grants 0,1 (ptr→2); cycle n+1 grants 2,3 (ptr→0).
- rsp_ready_i[1]=0 while slot 1 is valid -> no grants and rf_check_o=0 for 3 cycles. Slot 1 keeps its data; slot 0 drains. Grants resume the cycle after rsp_ready_i[1]=1.
